// File: rtl/sw_debounce_edge.sv
// Slide-switch front end: two-flop synchroniser, per-bit stable-count debounce,
// registered rise/fall pulses and a lowest-index event summary of the rise vector.
module sw_debounce_edge #(
    parameter int N       = 10,
    parameter int DEB_CYC = 500000,
    parameter int IDX_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     sw_raw,
    output logic [N-1:0]     sw_clean,
    output logic [N-1:0]     sw_rise,
    output logic [N-1:0]     sw_fall,
    output logic             evt_valid,
    output logic [IDX_W-1:0] evt_idx,
    output logic             evt_multi
);

    localparam int CNT_W = $clog2(DEB_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    logic [N-1:0]     sync1_r;
    logic [N-1:0]     sync2_r;
    logic [CNT_W-1:0] cnt_r     [N];
    logic [CNT_W-1:0] cnt_nxt_s [N];
    logic [N-1:0]     clean_nxt_s;
    logic [N-1:0]     rise_nxt_s;
    logic [N-1:0]     fall_nxt_s;

    // Lowest set index of v; zero when v is empty.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [N-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // True when more than one bit of v is set (clearing the lowest set bit leaves something).
    function automatic logic multi_set(input logic [N-1:0] v);
        return (v & (v - N'(1))) != {N{1'b0}};
    endfunction

    // Per-bit debounce decision: count disagreement with the clean level, commit on the last count.
    always_comb begin
        clean_nxt_s = sw_clean;
        rise_nxt_s  = {N{1'b0}};
        fall_nxt_s  = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            if (sync2_r[i] == sw_clean[i]) begin
                cnt_nxt_s[i] = {CNT_W{1'b0}};
            end else if (cnt_r[i] == CNT_LAST) begin
                cnt_nxt_s[i]   = {CNT_W{1'b0}};
                clean_nxt_s[i] = sync2_r[i];
                rise_nxt_s[i]  = sync2_r[i];
                fall_nxt_s[i]  = ~sync2_r[i];
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
            end
        end
    end

    // Synchroniser, counters, clean levels, pulses and event summary registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r   <= {N{1'b0}};
            sync2_r   <= {N{1'b0}};
            sw_clean  <= {N{1'b0}};
            sw_rise   <= {N{1'b0}};
            sw_fall   <= {N{1'b0}};
            evt_valid <= 1'b0;
            evt_idx   <= {IDX_W{1'b0}};
            evt_multi <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            sync1_r   <= sw_raw;
            sync2_r   <= sync1_r;
            sw_clean  <= clean_nxt_s;
            sw_rise   <= rise_nxt_s;
            sw_fall   <= fall_nxt_s;
            evt_valid <= (rise_nxt_s != {N{1'b0}});
            evt_idx   <= lowest_idx(rise_nxt_s);
            evt_multi <= multi_set(rise_nxt_s);
            for (int i = 0; i < N; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

endmodule
